// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    HALT  = 2'd2
  } ctrl_state_e;

  localparam int REG_IDX_W          = 5;
  localparam int DEF_TIMEOUT_CYCLES = 255;
endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the ID instruction's sources and an in-flight load.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_memRead,
  output logic                 lu
);
  // x0 is hardwired to zero, so a load targeting it never produces a hazard
  assign lu = ex_memRead && (ex_rd != '0) &&
              ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with data-memory wait FSM and sticky timeout.
// Optional perf counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_memRead,
  input  logic                 ex_branch_taken,
  input  logic                 mem_access,
  input  logic                 dmem_ready,
  output logic                 dmem_req,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 ifid_flush,
  output logic                 idex_en,
  output logic                 idex_flush,
  output logic                 exmem_en,
  output logic                 memwb_en,
  output logic                 memwb_flush,
  output logic                 bus_err,
`ifdef PIPE_CTRL_PERF_EN
  output logic [CNT_W-1:0]     perf_lu_stalls,
  output logic [CNT_W-1:0]     perf_mem_stalls,
  output logic [CNT_W-1:0]     perf_flushes,
`endif
  output logic [1:0]           ctrl_state
);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT_CYCLES);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             lu, lu_bubble, br_flush;

  load_use_detect u_lu (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_memRead (ex_memRead),
    .lu         (lu)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    dmem_req    = 1'b0;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    memwb_flush = 1'b0;
    lu_bubble   = 1'b0;
    br_flush    = 1'b0;
    unique case (state_q)
      RUN, MWAIT: begin
        dmem_req = (state_q == MWAIT) ? 1'b1 : mem_access;
        if ((state_q == MWAIT || mem_access) && !dmem_ready) begin
          // Freeze everything upstream of MEM; MEMWB takes a bubble each wait cycle
          memwb_en    = 1'b1;
          memwb_flush = 1'b1;
          if (state_q == RUN) begin
            state_d = MWAIT;
            cnt_d   = CNT_W'(1);
          end else if (cnt_q == TO_CNT) begin
            state_d = HALT;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d  = RUN;
          cnt_d    = '0;
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            br_flush   = 1'b1;
          end else if (lu) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            lu_bubble  = 1'b1;
          end
        end
      end
      default: state_d = HALT;
    endcase
    // Reset must quiesce the pipeline immediately, not at the next edge
    if (!rst_n) begin
      dmem_req    = 1'b0;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_en     = 1'b0;
      idex_flush  = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      memwb_flush = 1'b0;
      lu_bubble   = 1'b0;
      br_flush    = 1'b0;
    end
  end

  assign bus_err    = err_q;
  assign ctrl_state = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] lu_cnt_q, mem_cnt_q, fl_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_cnt_q  <= '0;
      mem_cnt_q <= '0;
      fl_cnt_q  <= '0;
    end else begin
      if (lu_bubble && !(&lu_cnt_q))            lu_cnt_q  <= lu_cnt_q + 1'b1;
      if (state_q == MWAIT && !(&mem_cnt_q))    mem_cnt_q <= mem_cnt_q + 1'b1;
      if (br_flush && !(&fl_cnt_q))             fl_cnt_q  <= fl_cnt_q + 1'b1;
    end
  end

  assign perf_lu_stalls  = lu_cnt_q;
  assign perf_mem_stalls = mem_cnt_q;
  assign perf_flushes    = fl_cnt_q;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: stimulus queues hand-computed output vectors, a monitor pops and compares.
module tb_pipeline_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_memRead = 1'b0;
  logic       ex_branch_taken = 1'b0, mem_access = 1'b0, dmem_ready = 1'b0;
  logic       dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic       exmem_en, memwb_en, memwb_flush, bus_err;
  logic [1:0] ctrl_state;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  string       name_q[$];
  event        chk_now;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memRead(ex_memRead), .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .memwb_flush(memwb_flush), .bus_err(bus_err),
    .ctrl_state(ctrl_state)
  );

  wire [11:0] act = {dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                     exmem_en, memwb_en, memwb_flush, bus_err, ctrl_state};

  // Field order: req pc ifid ifid_fl idex idex_fl exmem memwb memwb_fl err state
  function automatic logic [11:0] ev(input logic rq, pc, fi, fif, ie, ief, em, mw, mwf, er,
                                     input logic [1:0] st);
    return {rq, pc, fi, fif, ie, ief, em, mw, mwf, er, st};
  endfunction

  localparam logic [11:0] E_RST   = 12'h000;
  logic [11:0] e_run, e_runm, e_lu, e_br, e_mst, e_mw, e_mrdy, e_mrdy_lu, e_halt;

  // Apply one cycle of inputs just after the edge and queue what the outputs must be
  task automatic step(input string nm, input logic r, input logic [4:0] rs1, rs2,
                      input logic u1, u2, input logic [4:0] rd,
                      input logic mr, br, ma, rdy, input logic [11:0] e);
    @(posedge clk); #1;
    rst_n = r; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = rd; ex_memRead = mr; ex_branch_taken = br; mem_access = ma; dmem_ready = rdy;
    exp_q.push_back(e); name_q.push_back(nm);
  endtask

  // Drop reset mid-cycle and check before any clock edge
  task automatic async_rst(input string nm);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(E_RST); name_q.push_back(nm);
    ->chk_now;
  endtask

  initial begin : monitor
    logic [11:0] e;
    string nm;
    forever begin
      @(negedge clk or chk_now);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s actual=%h expected=%h", nm, act, e);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    e_run     = ev(0,1,1,0,1,0,1,1,0,0,2'd0);
    e_runm    = ev(1,1,1,0,1,0,1,1,0,0,2'd0);
    e_lu      = ev(0,0,0,0,1,1,1,1,0,0,2'd0);
    e_br      = ev(0,1,1,1,1,1,1,1,0,0,2'd0);
    e_mst     = ev(1,0,0,0,0,0,0,1,1,0,2'd0);
    e_mw      = ev(1,0,0,0,0,0,0,1,1,0,2'd1);
    e_mrdy    = ev(1,1,1,0,1,0,1,1,0,0,2'd1);
    e_mrdy_lu = ev(1,0,0,0,1,1,1,1,0,0,2'd1);
    e_halt    = ev(0,0,0,0,0,0,0,0,0,1,2'd2);

    //   name          rst rs1 rs2 u1 u2 rd  mr br ma rdy exp
    step("reset_hold",  0, 5,  5,  1, 1, 5,  1, 1, 1, 0, E_RST);
    step("run_idle",    1, 1,  2,  1, 1, 3,  0, 0, 0, 0, e_run);
    step("lu_rs1",      1, 5,  2,  1, 0, 5,  1, 0, 0, 0, e_lu);
    step("lu_after",    1, 5,  2,  1, 0, 9,  0, 0, 0, 0, e_run);
    step("lu_rs2",      1, 1,  7,  1, 1, 7,  1, 0, 0, 0, e_lu);
    step("lu_x0",       1, 0,  3,  1, 0, 0,  1, 0, 0, 0, e_run);
    step("lu_unused",   1, 6,  3,  0, 1, 6,  1, 0, 0, 0, e_run);
    step("br_and_lu",   1, 5,  2,  1, 0, 5,  1, 1, 0, 0, e_br);
    step("br_only",     1, 1,  2,  0, 0, 3,  0, 1, 0, 0, e_br);
    step("mem_fast",    1, 1,  2,  0, 0, 3,  0, 0, 1, 1, e_runm);
    // stall beats branch and load-use; then 3 wait cycles, ready with load-use pending
    step("mst_issue",   1, 5,  2,  1, 0, 5,  1, 1, 1, 0, e_mst);
    step("mwait_1",     1, 5,  2,  1, 0, 5,  1, 0, 1, 0, e_mw);
    step("mwait_2",     1, 5,  2,  1, 0, 5,  1, 0, 1, 0, e_mw);
    step("mwait_3",     1, 5,  2,  1, 0, 5,  1, 0, 0, 0, e_mw);
    step("mready_lu",   1, 5,  2,  1, 0, 5,  1, 0, 0, 1, e_mrdy_lu);
    step("run_back",    1, 1,  2,  0, 0, 3,  0, 0, 0, 0, e_run);
    step("mst_issue2",  1, 1,  2,  0, 0, 3,  0, 0, 1, 0, e_mst);
    step("mready_pl",   1, 1,  2,  0, 0, 3,  0, 0, 1, 1, e_mrdy);
    step("run_back2",   1, 1,  2,  0, 0, 3,  0, 0, 0, 0, e_run);
    // timeout: counter 1..4 in MWAIT, then sticky HALT
    step("to_issue",    1, 1,  2,  0, 0, 3,  0, 0, 1, 0, e_mst);
    step("to_w1",       1, 1,  2,  0, 0, 3,  0, 0, 1, 0, e_mw);
    step("to_w2",       1, 1,  2,  0, 0, 3,  0, 0, 1, 0, e_mw);
    step("to_w3",       1, 1,  2,  0, 0, 3,  0, 0, 1, 0, e_mw);
    step("to_w4",       1, 1,  2,  0, 0, 3,  0, 0, 1, 0, e_mw);
    step("halt_1",      1, 1,  2,  0, 0, 3,  0, 0, 1, 0, e_halt);
    step("halt_rdy",    1, 5,  2,  1, 0, 5,  1, 1, 1, 1, e_halt);
    async_rst("halt_rst");
    step("halt_clear",  1, 1,  2,  0, 0, 3,  0, 0, 0, 0, e_run);
    // async reset in the middle of a wait
    step("ar_issue",    1, 1,  2,  0, 0, 3,  0, 0, 1, 0, e_mst);
    step("ar_w1",       1, 1,  2,  0, 0, 3,  0, 0, 1, 0, e_mw);
    async_rst("ar_mid_wait");
    step("ar_held",     0, 1,  2,  0, 0, 3,  0, 0, 1, 0, E_RST);
    step("ar_release",  1, 1,  2,  0, 0, 3,  0, 0, 1, 1, e_runm);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives enable/flush of the PC and the IFID, IDEX, EXMEM and MEMWB pipeline registers.
- Inputs: load-use hazards (ID vs EX), taken branches/jumps resolved in EX, and a variable-latency data-memory req/ready handshake issued from MEM.
- Contains the data-memory wait FSM with timeout; sticky halt on timeout.

Parameters:
- TIMEOUT_CYCLES, 255: max consecutive wait cycles before bus error; 1..65535.
- CNT_W, 16: width of wait counter and optional perf counters.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs1  in  5  rs1 index of instruction in ID
- id_rs2  in  5  rs2 index of instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  destination of instruction in EX
- ex_memRead  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX redirects PC (branch taken/jal/jalr)
- mem_access  in  1  MEM instruction is load or store
- dmem_ready  in  1  data memory completes current access
- dmem_req  out  1  data memory request
- pc_en  out  1  PC update enable
- ifid_en  out  1  IFID load enable
- ifid_flush  out  1  IFID clear to NOP
- idex_en  out  1  IDEX load enable
- idex_flush  out  1  IDEX clear to bubble (controls zeroed)
- exmem_en  out  1  EXMEM load enable
- memwb_en  out  1  MEMWB load enable
- memwb_flush  out  1  MEMWB clear (regWrite=0, memToReg=0)
- bus_err  out  1  sticky timeout flag
- ctrl_state  out  2  current FSM state

Behaviour:
- States: RUN=0, MWAIT=1, HALT=2. Reset state RUN; wait counter 0; bus_err 0.
- Outputs are combinational from state and inputs (zero latency). During reset all enables 0, flushes 0, dmem_req 0.
- Load-use: lu = ex_memRead & ex_rd!=0 & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
- RUN, defaults: all enables 1, flushes 0.
- RUN, dmem_req = mem_access.
- RUN, mem_access & !dmem_ready: all enables 0, memwb_en=1, memwb_flush=1; next state MWAIT; counter <= 1. Memory stall overrides branch and load-use; the held EX instruction re-evaluates after the stall.
- RUN, no memory stall and ex_branch_taken: ifid_flush=1, idex_flush=1. Branch beats load-use (the ID instruction is squashed).
- RUN, no memory stall, lu, no branch: pc_en=0, ifid_en=0, idex_flush=1 (one bubble). Load-use costs exactly 1 cycle.
- MWAIT: dmem_req=1; pc_en, ifid_en, idex_en, exmem_en = 0; memwb_en=1, memwb_flush=1.
- MWAIT, dmem_ready: this cycle all enables 1, no flushes; the MEM result enters MEMWB; branch/lu rules above apply. Next state RUN; counter <= 0.
- MWAIT, !dmem_ready and counter==TIMEOUT_CYCLES: next state HALT; bus_err <= 1. Otherwise counter increments, saturating at TIMEOUT_CYCLES.
- HALT: all enables 0, flushes 0, dmem_req 0; exits only via rst_n.
- dmem_req stays high from issue until the ready cycle; never deasserts mid-access.
- rst_n low mid-wait: immediate return to RUN, counter 0, bus_err 0.
- ex_rd==0 never causes a stall.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined: adds outputs perf_lu_stalls, perf_mem_stalls, perf_flushes, each CNT_W bits. They count, respectively: load-use bubble cycles, MWAIT cycles, and taken-branch flush cycles. All saturate at max and reset to 0.
- Undefined: ports and counters absent; no other behaviour change.

Decomposition:
- Package pipe_ctrl_pkg: state enum (RUN, MWAIT, HALT), REG_IDX_W=5, default TIMEOUT_CYCLES.
- One sub-module, load_use_detect: combinational lu compare, reusable by the forwarding unit.

Test Plan:
- Load-use: ex_memRead=1, ex_rd=5, id_rs1=5, id_use_rs1=1, no mem_access -> one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables 1.
- ex_rd=0 with ex_memRead=1, id_rs1=0 -> no stall.
- Branch plus load-use in the same cycle -> ifid_flush=1, idex_flush=1, pc_en=1.
- mem_access=1 with dmem_ready low for 3 cycles, then high:
  - 3 cycles of MWAIT: exmem_en=0, memwb_flush=1, dmem_req=1.
  - Ready cycle: all enables 1, then RUN.
- TIMEOUT_CYCLES=4, dmem_ready held 0 -> HALT after 4 wait cycles; bus_err=1, all enables 0; rst_n pulse clears to RUN.
- rst_n asserted asynchronously mid-MWAIT -> ctrl_state=0, dmem_req=0 without waiting for a clock edge.
